// File: rtl/pipe_pkg.sv
// Shared types for pipe_stage_reg: skid FSM states, default widths, {ctrl,data} entry.
// No logic, no latency, no backpressure.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_CTRL_W = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [PIPE_CTRL_W-1:0] ctrl;
      logic [PIPE_DATA_W-1:0] data;
   } pipe_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry plus EMPTY/FULL/SKID state machine; tells the top when/what to load into main.
// Zero latency on load decode; ready_o is a flop, low only while the skid entry is occupied.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int W          = PIPE_DATA_W + PIPE_CTRL_W,
   parameter bit FLUSH_ZERO = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic         flush_i,
   input  logic         xfer_out_i,
   input  logic [W-1:0] entry_i,
   output logic         ready_o,
   output logic         load_o,
   output logic         load_skid_o,
   output logic [W-1:0] skid_o
);

   skid_state_e  state_q;
   logic         ready_q;
   logic [W-1:0] skid_q;
   logic         xfer_in;

   assign xfer_in     = valid_i & ready_q;
   assign ready_o     = ready_q;
   assign skid_o      = skid_q;
   assign load_skid_o = (state_q == SKID);
   // Main loads from input when it is empty or draining this cycle; from skid when SKID drains.
   assign load_o      = (xfer_in & ((state_q == EMPTY) | xfer_out_i))
                      | ((state_q == SKID) & xfer_out_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
         skid_q  <= '0;
      end else if (flush_i) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
         if (FLUSH_ZERO) skid_q <= '0;
      end else begin
         case (state_q)
            EMPTY: if (xfer_in) state_q <= FULL;
            FULL: begin
               if (xfer_in && !xfer_out_i) begin
                  state_q <= SKID;
                  skid_q  <= entry_i;
                  ready_q <= 1'b0;
               end else if (!xfer_in && xfer_out_i) begin
                  state_q <= EMPTY;
               end
            end
            SKID: begin
               if (xfer_out_i) begin
                  state_q <= FULL;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush > stall > flow priority; 1-cycle latency.
// Backpressure: combinational ready_o by default, registered 2-entry skid when PIPE_SKID_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_W,
   parameter int CTRL_WIDTH = PIPE_CTRL_W,
   parameter bit FLUSH_ZERO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   input  logic                  stall_i,
   input  logic                  flush_i
);

   localparam int ENTRY_W = DATA_WIDTH + CTRL_WIDTH;

   typedef struct packed {
      logic [CTRL_WIDTH-1:0] ctrl;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t in_ent, load_ent, main_q, main_d;
   logic   valid_q, valid_d;
   logic   load, xfer_out;

   assign in_ent   = {ctrl_i, data_i};
   assign xfer_out = valid_q & ready_i & ~stall_i;

`ifdef PIPE_SKID_EN
   logic               load_skid;
   logic [ENTRY_W-1:0] skid_ent;

   pipe_skid_buf #(
      .W          (ENTRY_W),
      .FLUSH_ZERO (FLUSH_ZERO)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (valid_i),
      .flush_i     (flush_i),
      .xfer_out_i  (xfer_out),
      .entry_i     (in_ent),
      .ready_o     (ready_o),
      .load_o      (load),
      .load_skid_o (load_skid),
      .skid_o      (skid_ent)
   );

   assign load_ent = load_skid ? entry_t'(skid_ent) : in_ent;
`else
   assign ready_o  = ~stall_i & (ready_i | ~valid_q);
   assign load     = valid_i & ready_o;
   assign load_ent = in_ent;
`endif

   always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush_i) begin
         valid_d = 1'b0;
         if (FLUSH_ZERO) main_d = '0;
      end else if (load) begin
         valid_d = 1'b1;
         main_d  = load_ent;
      end else if (xfer_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         main_q  <= '0;
      end else begin
         valid_q <= valid_d;
         main_q  <= main_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = main_q.data;
   // A bubble must never present live write enables downstream.
   assign ctrl_o  = valid_q ? main_q.ctrl : '0;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the hard-wired per-stage registers between the decode, execute, memory and writeback stages. It carries an arbitrary payload plus a control bundle, and adds valid/ready flow control, hazard-unit stall and flush, and an optional skid buffer. One instance sits at each stage boundary of the core.

## Interface
Parameters:
- DATA_WIDTH, 32: width of the data payload (operands, PC, PC+4, immediate concatenated by the instantiating stage)
- CTRL_WIDTH, 16: width of the decoded control bundle (ALU op, write enables, result select)
- FLUSH_ZERO, 1: 1 = flush also zeroes the payload and control; 0 = flush clears valid only

Ports:
- clk  input  1  stage clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream holds a valid item
- ready_o  output  1  stage can accept an item this cycle
- data_i  input  DATA_WIDTH  upstream payload
- ctrl_i  input  CTRL_WIDTH  upstream control bundle
- valid_o  output  1  stage holds a valid item
- ready_i  input  1  downstream accepts this cycle
- data_o  output  DATA_WIDTH  registered payload
- ctrl_o  output  CTRL_WIDTH  registered control; forced to 0 whenever valid_o=0
- stall_i  input  1  hazard-unit stall; holds the stage
- flush_i  input  1  hazard-unit flush; kills the stage contents

## Operation
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i & ~stall_i.
- Priority: flush_i > stall_i > normal flow.
- Flush: all stored entries invalidated next edge. An input transferred in the flush cycle is dropped. With FLUSH_ZERO=1, stored data/ctrl are cleared to 0.
- Stall: downstream transfer is blocked (stall_i acts as ready_i=0). valid_o, data_o and ctrl_o are held.
- Normal flow: output register loads on transfer in. valid_o clears when a transfer out happens with no transfer in.
- ctrl_o is gated by valid_o so a bubble never asserts write enables downstream.
- Data is never duplicated or reordered. Every accepted item leaves exactly once unless flushed.

## Timing
- Reset: valid_o=0, data_o=0, ctrl_o=0. ready_o=1 in skid mode; in non-skid mode it follows its combinational equation (1 when stall_i=0). The skid entry is invalid.
- Latency: 1 cycle from transfer in to valid_o, in both modes, when the stage is not backpressured.
- Throughput: 1 item/cycle under continuous valid_i=ready_i=1.
- Non-skid mode: ready_o = ~stall_i & (ready_i | ~valid_o), combinational.
- Skid mode: ready_o is a flop. States:
  - EMPTY: main entry invalid.
  - FULL: main entry valid.
  - SKID: main and skid entries both valid.
- Skid-mode transitions:
  - EMPTY→FULL on transfer in.
  - FULL→EMPTY on transfer out without transfer in.
  - FULL→SKID on transfer in without transfer out; the input goes to the skid entry.
  - SKID→FULL on transfer out; the skid entry moves to main.
  - Any state→EMPTY on flush.
- ready_o = 0 only in SKID. ready_o is 1 on the cycle after a flush.
- Reset asserted mid-operation clears all entries asynchronously. Outputs return to reset values without waiting for clk.

## Configuration
- PIPE_SKID_EN defined: adds the 2-entry skid buffer with a registered ready_o, which breaks the ready combinational path across stages.
- PIPE_SKID_EN undefined: single register only, with the combinational ready_o above. No skid storage is synthesised.
- Ports and latency are identical in both builds.

## Structure
- Shared package pipe_pkg holds:
  - the skid state enum (EMPTY, FULL, SKID)
  - the default DATA_WIDTH/CTRL_WIDTH constants
  - a typedef for the packed {ctrl, data} entry.
- Sub-module pipe_skid_buf, instantiated only under PIPE_SKID_EN, owns the skid entry and the state machine. The top owns the main register, flush/stall priority and ctrl gating.

## Test plan
- Reset then stream 8 items, data 0x1..0x8, ready_i=1 → valid_o rises 1 cycle after the first valid_i; data_o = 0x1..0x8 in order; no gaps.
- Hold 0xA5 in stage, assert stall_i for 3 cycles with valid_i=1 (data 0x11) → data_o=0xA5 held all 3 cycles. Non-skid: ready_o=0, 0x11 not taken. Skid: 0x11 enters skid, ready_o drops next cycle; 0xA5 then 0x11 emerge after release.
- Flush and stall asserted together with 0x33 valid and 0x44 arriving → next cycle valid_o=0, ctrl_o=0, data_o=0 (FLUSH_ZERO=1); 0x44 never appears.
- Skid build, ready_i=0 while feeding 0x5 then 0x6 → state SKID, ready_o=0; ready_i=1 → 0x5 then 0x6 out on consecutive cycles; ready_o=1 again.
- Drive rst_n low asynchronously between edges while in SKID → valid_o=0, data_o=0 immediately; ready_o=1 after release.
- Random valid_i/ready_i/stall_i/flush_i, 10k cycles, against a queue scoreboard → no loss, duplication or reordering of unflushed items; ctrl_o=0 whenever valid_o=0.
